pea_out_ctx_seq: RTL and testbench
==================================

PEA_OUT_CTX_SEQ -- requirements
Module: pea_out_ctx_seq

Interface
REQ-001 SHALL have parameter KMEM_SIZE, default pea_pkg::KMEM_SIZE, number of configuration contexts.
REQ-002 SHALL have parameter N_OUT_PEA, default pea_pkg::N_OUT_PEA, number of PEA outputs.
REQ-003 SHALL have parameter LOG_M, default xbar_pkg::LOG_M, width of one output selector.
REQ-004 SHALL have parameter CNT_W, default 16, width of the dwell counter.
REQ-005 SHALL have port clk_i  input  1  clock; the block uses one clock, all state on its rising edge.
REQ-006 SHALL have port rst_n_i  input  1  reset; reset is asynchronous and active-low.
REQ-007 SHALL have port reg_cfg_sel_out_pea_i  input  KMEM_SIZE*N_OUT_PEA*LOG_M  packed selectors; context c, output j occupies bits [((c*N_OUT_PEA+j+1)*LOG_M)-1 -: LOG_M].
REQ-008 SHALL have port start_i  input  1  start-sequence request.
REQ-009 SHALL have port abort_i  input  1  synchronous abort.
REQ-010 SHALL have port n_ctx_i  input  $clog2(KMEM_SIZE)+1  number of contexts to run.
REQ-011 SHALL have port ctx_len_i  input  CNT_W  active cycles per context.
REQ-012 SHALL have port stall_i  input  1  freezes the dwell counter.
REQ-013 SHALL have port sel_output_o  output  N_OUT_PEA x LOG_M  current output selectors.
REQ-014 SHALL have port ctx_idx_o  output  $clog2(KMEM_SIZE)  current context index.
REQ-015 SHALL have ports busy_o and done_o  output  1 each  running flag and one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 In IDLE, start_i=1 with n_ctx_i>0 SHALL snapshot reg_cfg_sel_out_pea_i into a shadow register, latch n_ctx (clamped to KMEM_SIZE), latch ctx_len (0 treated as 1), clear ctx_idx and the dwell counter, and enter RUN next cycle.
REQ-018 In IDLE, start_i=1 with n_ctx_i=0 SHALL go to DONE directly, skipping RUN.
REQ-019 In RUN, sel_output_o SHALL equal the shadow slice for ctx_idx_o, so the first cycle after start shows context 0; in IDLE and DONE it SHALL be all-zero.
REQ-020 In RUN, the dwell counter SHALL increment only when stall_i=0.
REQ-021 When the counter equals ctx_len-1 and stall_i=0, the block SHALL clear the counter and increment ctx_idx; if ctx_idx is n_ctx-1, it SHALL enter DONE instead.
REQ-022 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-023 busy_o SHALL be 1 exactly in RUN.
REQ-024 start_i SHALL be ignored outside IDLE.
REQ-025 Changes to reg_cfg_sel_out_pea_i during RUN SHALL NOT affect sel_output_o.
REQ-026 abort_i=1 in any state SHALL force IDLE next cycle with no done_o pulse, and SHALL take priority over start_i and context advance.

Reset
REQ-027 Asserting rst_n_i=0, including mid-RUN, SHALL immediately force IDLE and set ctx_idx_o=0, sel_output_o=0, busy_o=0, done_o=0, counter=0 and shadow register=0.

Configuration
REQ-028 With macro PEA_OUT_SEQ_LOOP_EN defined, the block SHALL add input loop_i (1 bit), latched at start; when the latched value is 1, the step after the last context SHALL wrap ctx_idx to 0 and stay in RUN until abort_i, and done_o SHALL never assert.
REQ-029 Without PEA_OUT_SEQ_LOOP_EN, the loop_i port and its logic SHALL be absent and every sequence SHALL be single-pass.

Verification (bench: KMEM_SIZE=4, N_OUT_PEA=4, LOG_M=3)
REQ-030 Basic run: start with n_ctx=3, ctx_len=2, no stall -> ctx_idx_o = 0,0,1,1,2,2 over six RUN cycles, busy_o=1 for 6 cycles, then done_o=1 for one cycle.
REQ-031 Stall: n_ctx=1, ctx_len=3, stall_i=1 on RUN cycle 2 -> RUN lasts 4 cycles, then done_o.
REQ-032 Edge counts: n_ctx=0 -> done_o one cycle after start with busy_o never set; n_ctx=7 -> clamps to 4 contexts; ctx_len=0 -> behaves as 1.
REQ-033 Abort and reset: abort_i on RUN cycle 3 -> IDLE next cycle with no done_o; same scenario with rst_n_i low mid-RUN -> all outputs 0 at once.
REQ-034 Snapshot: rewrite context 1 selectors during context 0 -> sel_output_o shows the old context-1 values; start_i pulsed while busy -> no restart.
REQ-035 Loop (macro defined, loop_i=1, n_ctx=2, ctx_len=1) -> ctx_idx_o = 0,1,0,1,... with no done_o until abort_i.

Source files
------------

// File: rtl/pea_out_ctx_seq.sv
// Output-selector context sequencer: snapshots all contexts at start, then steps through them.
// Optional PEA_OUT_SEQ_LOOP_EN adds loop_i for endless wrap-around sequencing.

package pea_pkg;
    parameter int unsigned KMEM_SIZE = 4;
    parameter int unsigned N_OUT_PEA = 4;
endpackage

package xbar_pkg;
    parameter int unsigned LOG_M = 3;
endpackage

module pea_out_ctx_seq #(
    parameter int unsigned KMEM_SIZE = pea_pkg::KMEM_SIZE,
    parameter int unsigned N_OUT_PEA = pea_pkg::N_OUT_PEA,
    parameter int unsigned LOG_M     = xbar_pkg::LOG_M,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic [KMEM_SIZE*N_OUT_PEA*LOG_M-1:0]  reg_cfg_sel_out_pea_i,
    input  logic                                  start_i,
    input  logic                                  abort_i,
    input  logic [$clog2(KMEM_SIZE):0]            n_ctx_i,
    input  logic [CNT_W-1:0]                      ctx_len_i,
    input  logic                                  stall_i,
`ifdef PEA_OUT_SEQ_LOOP_EN
    input  logic                                  loop_i,
`endif
    output logic [N_OUT_PEA-1:0][LOG_M-1:0]       sel_output_o,
    output logic [$clog2(KMEM_SIZE)-1:0]          ctx_idx_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int unsigned IDX_W   = $clog2(KMEM_SIZE);
    localparam int unsigned NCTX_W  = IDX_W + 1;
    localparam int unsigned SLICE_W = N_OUT_PEA * LOG_M;
    localparam int unsigned CFG_W   = KMEM_SIZE * SLICE_W;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NCTX_W-1:0]   n_ctx_q, n_ctx_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CFG_W-1:0]    shadow_q, shadow_d;
`ifdef PEA_OUT_SEQ_LOOP_EN
    logic                loop_q, loop_d;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            n_ctx_q  <= '0;
            len_q    <= '0;
            shadow_q <= '0;
`ifdef PEA_OUT_SEQ_LOOP_EN
            loop_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            n_ctx_q  <= n_ctx_d;
            len_q    <= len_d;
            shadow_q <= shadow_d;
`ifdef PEA_OUT_SEQ_LOOP_EN
            loop_q   <= loop_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        n_ctx_d  = n_ctx_q;
        len_d    = len_q;
        shadow_d = shadow_q;
`ifdef PEA_OUT_SEQ_LOOP_EN
        loop_d   = loop_q;
`endif
        // Abort outranks both start and context advance.
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (n_ctx_i == '0) begin
                            state_d = StDone;
                        end else begin
                            state_d  = StRun;
                            shadow_d = reg_cfg_sel_out_pea_i;
                            n_ctx_d  = (n_ctx_i > NCTX_W'(KMEM_SIZE)) ? NCTX_W'(KMEM_SIZE)
                                                                     : n_ctx_i;
                            len_d    = (ctx_len_i == '0) ? CNT_W'(1) : ctx_len_i;
                            idx_d    = '0;
                            cnt_d    = '0;
`ifdef PEA_OUT_SEQ_LOOP_EN
                            loop_d   = loop_i;
`endif
                        end
                    end
                end
                StRun: begin
                    if (!stall_i) begin
                        if (cnt_q == len_q - CNT_W'(1)) begin
                            cnt_d = '0;
                            if ({1'b0, idx_q} == n_ctx_q - NCTX_W'(1)) begin
`ifdef PEA_OUT_SEQ_LOOP_EN
                                if (loop_q) idx_d = '0;
                                else        state_d = StDone;
`else
                                state_d = StDone;
`endif
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        sel_output_o = '0;
        if (state_q == StRun) begin
            for (int c = 0; c < KMEM_SIZE; c++) begin
                if (idx_q == c[IDX_W-1:0]) begin
                    sel_output_o = shadow_q[c*SLICE_W +: SLICE_W];
                end
            end
        end
    end

    assign ctx_idx_o = idx_q;
    assign busy_o    = (state_q == StRun);
    assign done_o    = (state_q == StDone);

endmodule

// File: tb/tb_pea_out_ctx_seq.sv
// Directed self-checking bench for pea_out_ctx_seq (KMEM_SIZE=4, N_OUT_PEA=4, LOG_M=3).
// Define PEA_OUT_SEQ_LOOP_EN to also exercise loop mode.

module tb_pea_out_ctx_seq;

    localparam int unsigned KMEM_SIZE = 4;
    localparam int unsigned N_OUT_PEA = 4;
    localparam int unsigned LOG_M     = 3;
    localparam int unsigned CNT_W     = 16;

    logic                                 clk;
    logic                                 rst_n;
    logic [KMEM_SIZE*N_OUT_PEA*LOG_M-1:0] cfg;
    logic                                 start;
    logic                                 abort;
    logic [2:0]                           n_ctx;
    logic [CNT_W-1:0]                     ctx_len;
    logic                                 stall;
    logic [N_OUT_PEA-1:0][LOG_M-1:0]      sel_output;
    logic [1:0]                           ctx_idx;
    logic                                 busy;
    logic                                 done;
`ifdef PEA_OUT_SEQ_LOOP_EN
    logic                                 loop;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-picked per-context selector slices, context 0 in the low bits.
    localparam logic [11:0] CTX0 = 12'h0A1;
    localparam logic [11:0] CTX1 = 12'h5B2;
    localparam logic [11:0] CTX2 = 12'hC3D;
    localparam logic [11:0] CTX3 = 12'hE4F;
    localparam logic [47:0] CFG_INIT = {CTX3, CTX2, CTX1, CTX0};

    pea_out_ctx_seq #(
        .KMEM_SIZE (KMEM_SIZE),
        .N_OUT_PEA (N_OUT_PEA),
        .LOG_M     (LOG_M),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i                 (clk),
        .rst_n_i               (rst_n),
        .reg_cfg_sel_out_pea_i (cfg),
        .start_i               (start),
        .abort_i               (abort),
        .n_ctx_i               (n_ctx),
        .ctx_len_i             (ctx_len),
        .stall_i               (stall),
`ifdef PEA_OUT_SEQ_LOOP_EN
        .loop_i                (loop),
`endif
        .sel_output_o          (sel_output),
        .ctx_idx_o             (ctx_idx),
        .busy_o                (busy),
        .done_o                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [2:0] n, input logic [CNT_W-1:0] len);
        n_ctx   = n;
        ctx_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    logic [11:0] ctx_tab [4];
    int          exp_idx [6];

    initial begin
        ctx_tab = '{CTX0, CTX1, CTX2, CTX3};
        rst_n   = 1'b0;
        cfg     = CFG_INIT;
        start   = 1'b0;
        abort   = 1'b0;
        n_ctx   = '0;
        ctx_len = '0;
        stall   = 1'b0;
`ifdef PEA_OUT_SEQ_LOOP_EN
        loop    = 1'b0;
`endif
        #12;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_idx", 32'(ctx_idx), 0);
        check("reset_sel", 32'(sel_output), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic run: 3 contexts x 2 cycles.
        kick(3'd3, 16'd2);
        exp_idx = '{0, 0, 1, 1, 2, 2};
        for (int i = 0; i < 6; i++) begin
            check($sformatf("basic_idx%0d", i), 32'(ctx_idx), 32'(exp_idx[i]));
            check($sformatf("basic_busy%0d", i), 32'(busy), 1);
            check($sformatf("basic_sel%0d", i), 32'(sel_output), 32'(ctx_tab[exp_idx[i]]));
            check($sformatf("basic_nodone%0d", i), 32'(done), 0);
            tick();
        end
        check("basic_done", 32'(done), 1);
        check("basic_done_busy", 32'(busy), 0);
        check("basic_done_sel", 32'(sel_output), 0);
        tick();
        check("basic_idle_done", 32'(done), 0);

        // Stall on RUN cycle 2 stretches a 3-cycle context to 4.
        kick(3'd1, 16'd3);
        check("stall_c1", 32'(busy), 1);
        tick();
        check("stall_c2", 32'(busy), 1);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        check("stall_c3", 32'(busy), 1);
        tick();
        check("stall_c4", 32'(busy), 1);
        check("stall_c4_nodone", 32'(done), 0);
        tick();
        check("stall_done", 32'(done), 1);
        check("stall_done_busy", 32'(busy), 0);
        tick();

        // n_ctx = 0 goes straight to DONE.
        kick(3'd0, 16'd2);
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        tick();
        check("zero_after", 32'(done), 0);
        check("zero_after_busy", 32'(busy), 0);

        // n_ctx = 7 clamps to 4 contexts.
        kick(3'd7, 16'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clamp_idx%0d", i), 32'(ctx_idx), 32'(i));
            check($sformatf("clamp_busy%0d", i), 32'(busy), 1);
            check($sformatf("clamp_sel%0d", i), 32'(sel_output), 32'(ctx_tab[i]));
            tick();
        end
        check("clamp_done", 32'(done), 1);
        tick();

        // ctx_len = 0 behaves as 1.
        kick(3'd2, 16'd0);
        check("len0_idx0", 32'(ctx_idx), 0);
        tick();
        check("len0_idx1", 32'(ctx_idx), 1);
        check("len0_busy1", 32'(busy), 1);
        tick();
        check("len0_done", 32'(done), 1);
        tick();

        // Abort on RUN cycle 3.
        kick(3'd3, 16'd2);
        tick();
        tick();
        check("abort_c3_busy", 32'(busy), 1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_sel", 32'(sel_output), 0);
        tick();
        check("abort_nodone", 32'(done), 0);
        check("abort_stays_idle", 32'(busy), 0);

        // Asynchronous reset mid-RUN.
        kick(3'd3, 16'd2);
        tick();
        tick();
        check("rst_c3_idx", 32'(ctx_idx), 1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_idx", 32'(ctx_idx), 0);
        check("rst_sel", 32'(sel_output), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_after_done", 32'(done), 0);

        // Snapshot isolation and start ignored while busy.
        kick(3'd2, 16'd2);
        check("snap_c1_sel", 32'(sel_output), 32'(CTX0));
        cfg[23:12] = 12'h777;
        tick();
        n_ctx = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("snap_c3_idx", 32'(ctx_idx), 1);
        check("snap_c3_sel", 32'(sel_output), 32'(CTX1));
        tick();
        check("snap_c4_sel", 32'(sel_output), 32'(CTX1));
        tick();
        check("snap_done", 32'(done), 1);
        tick();
        cfg = CFG_INIT;

`ifdef PEA_OUT_SEQ_LOOP_EN
        loop = 1'b1;
        kick(3'd2, 16'd1);
        loop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("loop_idx%0d", i), 32'(ctx_idx), 32'(i % 2));
            check($sformatf("loop_busy%0d", i), 32'(busy), 1);
            check($sformatf("loop_nodone%0d", i), 32'(done), 0);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("loop_abort_busy", 32'(busy), 0);
        check("loop_abort_done", 32'(done), 0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
